// File: rtl/multiply_matrix_if.sv
// multiply_matrix_if: strobes, operand rows and result lanes of the vector-by-matrix engine
interface multiply_matrix_if #(
    parameter int N    = 8,
    parameter int DW   = 8,
    parameter int ACCW = 20
);
    logic                load_w;
    logic [N*DW-1:0]     b;
    logic                load;
    logic [N*DW-1:0]     a;
    logic [N*ACCW-1:0]   c;
    logic [N*ACCW-1:0]   out;
    logic                out_valid;
    modport master (output load_w, b, load, a, c, input out, out_valid);
    modport slave  (input load_w, b, load, a, c, output out, out_valid);
endinterface

// File: rtl/multiply_matrix.sv
// multiply_matrix: row-streamed A*W (+C) multiply-accumulate with an 8x8 weight store
module multiply_matrix #(
    parameter int N    = 8,
    parameter int DW   = 8,
    parameter int ACCW = 20
) (
    input logic               clk,
    input logic               reset,
    multiply_matrix_if.slave  bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] LAST = PW'(N - 1);
    logic [DW-1:0]     w [N][N];
    logic [PW-1:0]     wptr;
    logic [N*ACCW-1:0] sum;
    logic [ACCW-1:0]   acc;
    // column sums over the weights held before the edge, wrapping at ACCW bits
    always_comb begin
        sum = '0;
        acc = '0;
        for (int j = 0; j < N; j++) begin
            acc = bus.c[j*ACCW +: ACCW];
            for (int k = 0; k < N; k++)
                acc = acc + ACCW'(bus.a[k*DW +: DW]) * ACCW'(w[k][j]);
            sum[j*ACCW +: ACCW] = acc;
        end
    end
    // weight row writes, pointer wrap, and one-cycle registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++)
                for (int j = 0; j < N; j++)
                    w[k][j] <= '0;
            wptr          <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            if (bus.load_w) begin
                for (int j = 0; j < N; j++)
                    w[wptr][j] <= bus.b[j*DW +: DW];
                wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            end
            if (bus.load)
                bus.out <= sum;
            bus.out_valid <= bus.load;
        end
    end
endmodule

// File: tb/tb_multiply_matrix.sv
// tb_multiply_matrix: directed and randomized checks against a behavioural matrix model
module tb_multiply_matrix;
    logic clk = 1'b0;
    logic reset;
    multiply_matrix_if bus ();
    multiply_matrix dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int wm [8][8];
    int wp;
    logic [159:0] eo;
    logic         ev;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [159:0] ref_row(input logic [63:0] av, input logic [159:0] cv);
        logic [159:0] r;
        longint s;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            s = longint'(cv[20*j +: 20]);
            for (int k = 0; k < 8; k++) s += longint'(av[8*k +: 8]) * wm[k][j];
            r[20*j +: 20] = 20'(s % (64'd1 << 20));
        end
        return r;
    endfunction

    function automatic logic [159:0] rep(input logic [19:0] v);
        logic [159:0] r;
        for (int j = 0; j < 8; j++) r[20*j +: 20] = v;
        return r;
    endfunction

    task automatic cyc(input logic r, input logic lw, input logic [63:0] bv,
                       input logic ld, input logic [63:0] av, input logic [159:0] cv);
        reset = r; bus.load_w = lw; bus.b = bv; bus.load = ld; bus.a = av; bus.c = cv;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 8; k++) for (int j = 0; j < 8; j++) wm[k][j] = 0;
            wp = 0; eo = '0; ev = 1'b0;
        end else begin
            if (ld) eo = ref_row(av, cv);
            ev = ld;
            if (lw) begin
                for (int j = 0; j < 8; j++) wm[wp][j] = int'(bv[8*j +: 8]);
                wp = (wp + 1) % 8;
            end
        end
        #1;
        check("out", bus.out, eo);
        check("out_valid", 160'(bus.out_valid), 160'(ev));
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [159:0] r160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [159:0] cl;
        logic [159:0] held;
        reset = 1'b1; bus.load_w = 0; bus.b = '0; bus.load = 0; bus.a = '0; bus.c = '0;
        cyc(1, 0, 0, 0, 0, 0);
        check("reset_out", bus.out, '0);
        // identity weights
        for (int i = 0; i < 8; i++) cyc(0, 1, 64'h01 << (8*i), 0, 0, 0);
        cyc(0, 0, 0, 1, 64'h0807060504030201, 0);
        for (int j = 0; j < 8; j++) cl[20*j +: 20] = 20'(j + 1);
        check("identity", bus.out, cl);
        check("identity_valid", 160'(bus.out_valid), 160'(1));
        // saturating inputs, with and without wrap-around addend
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, '1, 0, 0, 0);
        cyc(0, 0, 0, 1, '1, 0);
        check("max", bus.out, rep(20'h7F008));
        cyc(0, 0, 0, 1, '1, rep(20'hFFFFF));
        check("max_wrap", bus.out, rep(20'h7F007));
        // zero weights after reset: out = c
        cyc(1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++) cl[20*j +: 20] = 20'(j * 20'h11111);
        cyc(0, 0, 0, 1, '1, cl);
        check("addend_only", bus.out, cl);
        // ninth write wraps into row 0
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 64'h0101010101010101, 0, 0, 0);
        cyc(0, 0, 0, 1, 64'h01, 0);
        check("ptr_wrap", bus.out, rep(20'd1));
        // streaming with random weights, then hold
        for (int i = 0; i < 8; i++) cyc(0, 1, r64(), 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, r64(), r160());
        held = eo;
        cyc(0, 0, 0, 0, r64(), r160());
        check("hold", bus.out, held);
        cyc(0, 0, 0, 0, r64(), r160());
        check("hold2", bus.out, held);
        // simultaneous load and load_w uses pre-edge weights
        cyc(0, 1, r64(), 1, r64(), r160());
        cyc(0, 1, r64(), 1, r64(), r160());
        cyc(0, 0, 0, 1, r64(), r160());
        // reset during a load burst
        cyc(0, 0, 0, 1, r64(), r160());
        cyc(1, 0, 0, 1, r64(), r160());
        check("midreset_out", bus.out, '0);
        check("midreset_valid", 160'(bus.out_valid), 160'(0));
        cl = r160();
        cyc(0, 0, 0, 1, r64(), cl);
        check("after_reset", bus.out, cl);
        // random mixed traffic
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 39) == 0, 1'($urandom), r64(), 1'($urandom), r64(), r160());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
